// File: rtl/demux_buffer.sv
// One-to-four distributor: steers each accepted word into a one-entry holding slot per channel.
// Optional DEMUX_BROADCAST_EN adds in_broadcast_i, loading all four slots at once when all are free.
module demux_buffer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic [1:0]       in_select_i,
    input  logic             in_valid_i,
`ifdef DEMUX_BROADCAST_EN
    input  logic             in_broadcast_i,
`endif
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_a_o,
    output logic [WIDTH-1:0] out_b_o,
    output logic [WIDTH-1:0] out_c_o,
    output logic [WIDTH-1:0] out_d_o,
    output logic [3:0]       out_valid_o,
    input  logic [3:0]       out_ack_i
);

    logic [3:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];

    logic [3:0] free;
    logic [3:0] sel_onehot;
    logic [3:0] wr_en;
    logic       bcast_req;
    logic       ready;
    logic       accept;

    // A slot being acked this cycle counts as free, so it can be refilled in the same cycle.
    always_comb begin
        free       = ~valid_q | out_ack_i;
        sel_onehot = 4'b0001 << in_select_i;
        bcast_req  = 1'b0;
`ifdef DEMUX_BROADCAST_EN
        bcast_req  = in_valid_i & in_broadcast_i;
`endif
        ready  = bcast_req ? (&free) : free[in_select_i];
        accept = in_valid_i & ready;
        if (!accept) begin
            wr_en = 4'b0000;
        end else if (bcast_req) begin
            wr_en = 4'b1111;
        end else begin
            wr_en = sel_onehot;
        end
    end

    // Data is never cleared on ack; only the valid bit drops.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            valid_d[i] = wr_en[i] | (valid_q[i] & ~out_ack_i[i]);
            data_d[i]  = wr_en[i] ? in_data_i : data_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < 4; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign in_ready_o  = ready;
    assign out_valid_o = valid_q;
    assign out_a_o     = data_q[0];
    assign out_b_o     = data_q[1];
    assign out_c_o     = data_q[2];
    assign out_d_o     = data_q[3];

endmodule

// File: tb/tb_demux_buffer.sv
// Bench for demux_buffer: directed scenarios plus randomized traffic against a slot-level model.
// Broadcast scenarios are built only when DEMUX_BROADCAST_EN is defined.
module tb_demux_buffer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] in_data = '0;
    logic [1:0]   in_sel = '0;
    logic         in_valid = 1'b0;
    logic         in_bcast = 1'b0;
    logic         in_ready;
    logic [W-1:0] out_a, out_b, out_c, out_d;
    logic [3:0]   out_valid;
    logic [3:0]   out_ack = '0;

    logic [W-1:0] dut_out [4];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: each channel is a slot that is either holding a word or empty.
    logic [3:0]   m_valid = '0;
    logic [W-1:0] m_data [4];
    logic         last_rdy;

    demux_buffer #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data_i     (in_data),
        .in_select_i   (in_sel),
        .in_valid_i    (in_valid),
`ifdef DEMUX_BROADCAST_EN
        .in_broadcast_i(in_bcast),
`endif
        .in_ready_o    (in_ready),
        .out_a_o       (out_a),
        .out_b_o       (out_b),
        .out_c_o       (out_c),
        .out_d_o       (out_d),
        .out_valid_o   (out_valid),
        .out_ack_i     (out_ack)
    );

    assign dut_out[0] = out_a;
    assign dut_out[1] = out_b;
    assign dut_out[2] = out_c;
    assign dut_out[3] = out_d;

    always #5 clk = ~clk;

    property p_valid_held;
        @(posedge clk) disable iff (!rst_n) (in_valid && !in_ready) |=> in_valid;
    endproperty
    assert property (p_valid_held)
        else $error("FAIL sender_hold: in_valid=0 required 1");

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_valid = '0;
        for (int i = 0; i < 4; i++) m_data[i] = '0;
    endtask

    // A channel can take a word if it is empty or its consumer is draining it right now.
    function automatic logic model_ready();
        logic can_take [4];
        logic all_take;
        all_take = 1'b1;
        for (int i = 0; i < 4; i++) begin
            can_take[i] = !m_valid[i] || out_ack[i];
            all_take    = all_take && can_take[i];
        end
        if (in_valid && in_bcast) return all_take;
        return can_take[in_sel];
    endfunction

    // Called at posedge+1 with inputs driven; checks mid-cycle and advances one clock.
    task automatic cycle();
        logic         exp_rdy;
        logic [3:0]   nv;
        logic [W-1:0] nd [4];
        #3;
        exp_rdy = model_ready();
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
        for (int i = 0; i < 4; i++) begin
            check($sformatf("out_%c", 8'h61 + i), {16'd0, dut_out[i]}, {16'd0, m_data[i]});
        end
        last_rdy = in_ready;
        for (int i = 0; i < 4; i++) begin
            nv[i] = m_valid[i] && !out_ack[i];
            nd[i] = m_data[i];
            if (in_valid && exp_rdy && (in_bcast || in_sel == 2'(i))) begin
                nv[i] = 1'b1;
                nd[i] = in_data;
            end
        end
        @(posedge clk);
        m_valid = nv;
        for (int i = 0; i < 4; i++) m_data[i] = nd[i];
        #1;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic [1:0] s, input logic v,
                         input logic [3:0] a);
        in_data  = d;
        in_sel   = s;
        in_valid = v;
        out_ack  = a;
        in_bcast = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] d, input logic [1:0] s);
        drive(d, s, 1'b1, 4'b0000);
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        bit pend;
        model_clear();
        #2;
        check("rst_valid", {28'd0, out_valid}, 32'd0);
        check("rst_a", {16'd0, out_a}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("rst_ready", {31'd0, last_rdy}, 32'd1);

        // Mid-cycle reset with all channels full
        send(16'h1111, 2'd0);
        send(16'h2222, 2'd1);
        send(16'h3333, 2'd2);
        send(16'h4444, 2'd3);
        drive(16'h5555, 2'd1, 1'b1, 4'b0000);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {28'd0, out_valid}, 32'd0);
        check("midrst_a", {16'd0, out_a}, 32'd0);
        check("midrst_d", {16'd0, out_d}, 32'd0);
        model_clear();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        check("midrst_ready", {31'd0, last_rdy}, 32'd1);

        // Single unicast write to C
        send(16'h1234, 2'd2);
        check("t2_c", {16'd0, out_c}, 32'h1234);
        check("t2_valid", {28'd0, out_valid}, 32'h4);
        check("t2_a", {16'd0, out_a}, 32'd0);

        // Stall on full B, then same-cycle refill on ack
        send(16'h1111, 2'd1);
        drive(16'hBEEF, 2'd1, 1'b1, 4'b0000);
        cycle();
        check("t3_stall_ready", {31'd0, last_rdy}, 32'd0);
        check("t3_b_hold", {16'd0, out_b}, 32'h1111);
        out_ack = 4'b0010;
        cycle();
        check("t3_ack_ready", {31'd0, last_rdy}, 32'd1);
        check("t3_b_new", {16'd0, out_b}, 32'hBEEF);
        check("t3_b_valid", {31'd0, out_valid[1]}, 32'd1);
        drive(16'h0, 2'd0, 1'b0, 4'b0000);

        // Ack A while writing D
        send(16'h00AA, 2'd0);
        drive(16'h00FF, 2'd3, 1'b1, 4'b0001);
        cycle();
        check("t4_valid", {28'd0, out_valid}, 32'hE);
        check("t4_d", {16'd0, out_d}, 32'h00FF);
        check("t4_a_kept", {16'd0, out_a}, 32'h00AA);

        // Drain all four at once; data retained
        send(16'h0A0A, 2'd0);
        drive(16'h0, 2'd0, 1'b0, 4'b1111);
        cycle();
        check("t5_valid", {28'd0, out_valid}, 32'd0);
        check("t5_a", {16'd0, out_a}, 32'h0A0A);
        check("t5_b", {16'd0, out_b}, 32'hBEEF);
        check("t5_c", {16'd0, out_c}, 32'h1234);
        check("t5_d", {16'd0, out_d}, 32'h00FF);
        cycle();
        check("t5_empty_ack", {28'd0, out_valid}, 32'd0);

`ifdef DEMUX_BROADCAST_EN
        // Broadcast blocked by full C, released by its ack
        send(16'h2222, 2'd2);
        drive(16'hA5A5, 2'd0, 1'b1, 4'b0000);
        in_bcast = 1'b1;
        cycle();
        check("t6_stall_ready", {31'd0, last_rdy}, 32'd0);
        out_ack = 4'b0100;
        cycle();
        check("t6_ack_ready", {31'd0, last_rdy}, 32'd1);
        check("t6_valid", {28'd0, out_valid}, 32'hF);
        check("t6_a", {16'd0, out_a}, 32'hA5A5);
        check("t6_d", {16'd0, out_d}, 32'hA5A5);
        drive(16'h0, 2'd0, 1'b0, 4'b1111);
        cycle();
`endif

        // Randomized traffic; sender holds a word until it sees ready
        pend = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!pend && $urandom_range(3) != 0) begin
                pend     = 1'b1;
                in_data  = W'($urandom);
                in_sel   = 2'($urandom_range(3));
`ifdef DEMUX_BROADCAST_EN
                in_bcast = ($urandom_range(4) == 0);
`else
                in_bcast = 1'b0;
`endif
            end
            in_valid = pend;
            out_ack  = 4'($urandom_range(15)) & 4'($urandom_range(15));
            cycle();
            if (pend && last_rdy) pend = 1'b0;
        end

        in_valid = 1'b0;
        out_ack  = '0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
